prf_read_stage: RTL and testbench
=================================

Name: prf_read_stage

Overview:
- Register-read pipeline stage directly upstream of the 12-read/6-write physical register file (32 x 32 by default).
- Accepts issue packets for 6 lanes with 2 source operands each, and drives the file's 12 read addresses from its S1 register.
- Merges file read data with same-cycle writeback bypass from the file's 6 write ports.
- Delivers complete operand packets through an S2 output register, using a valid/ready handshake with stall and flush.

Parameters:
- SRAM_DEPTH, 32, number of physical registers.
- SRAM_INDEX, 5, physical register address width (log2 SRAM_DEPTH).
- SRAM_WIDTH, 32, register data width.
- LANES, 6, issue lanes; read ports = 2*LANES, fixed at 12 for this configuration.
- WR_PORTS, 6, writeback ports snooped for bypass.
- PAYLOAD_WIDTH, 16, opaque per-lane payload carried alongside operands.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled at posedge clk, 0 = reset.
- flush_i  in  1  squashes all in-flight packets.
- issue_valid_i  in  LANES  per-lane valid of the incoming issue packet.
- issue_ready_o  out  1  stage accepts a packet this cycle.
- src_addr_i  in  2*LANES*SRAM_INDEX  operand k of lane l at slot 2l+k.
- payload_i  in  LANES*PAYLOAD_WIDTH  per-lane payload.
- rd_addr_o  out  2*LANES*SRAM_INDEX  to file read addresses addr0..addr11 (slot order).
- rd_data_i  in  2*LANES*SRAM_WIDTH  from file read data data0..data11 (combinational).
- wr_we_i  in  WR_PORTS  copy of the file write enables we0..we5.
- wr_addr_i  in  WR_PORTS*SRAM_INDEX  copy of the file write addresses.
- wr_data_i  in  WR_PORTS*SRAM_WIDTH  copy of the file write data.
- out_valid_o  out  LANES  per-lane valid of the S2 packet.
- out_ready_i  in  1  consumer accepts the S2 packet.
- out_operand_o  out  2*LANES*SRAM_WIDTH  resolved operands, slot order.
- out_payload_o  out  LANES*PAYLOAD_WIDTH  S2 payload.

Behaviour:
- Two registers, S1 and S2. Each holds per-lane valid bits, 12 addresses (S1) or 12 operands (S2), and payloads.
- Stage occupancy is the OR of its valid bits.
- Advance rules:
  - s2_adv = !S2occ | out_ready_i.
  - s1_adv = !S1occ | s2_adv.
  - issue_ready_o = s1_adv; it is purely combinational, with no dependency on issue_valid_i.
- Transfer into S1: when issue_ready_o and |issue_valid_i, S1 loads the packet. When issue_ready_o and no lane is valid, S1 valid clears.
- Transfer into S2: when s2_adv, S2 loads S1 valid, payload and resolved operands. Operands are captured only for valid lanes; invalid lanes' data is don't-care.
- rd_addr_o = S1 addresses, at all times.
- Operand resolution is combinational in the S1 cycle. For each slot:
  - If any w has wr_we_i[w] and wr_addr_i[w] == addr, select wr_data_i of the highest-numbered matching port. This matches the file's last-write-wins ordering.
  - Otherwise select rd_data_i.
- Latency: issue accepted at edge N gives out_valid_o at edge N+1 (one cycle in S1, presented from S2), provided there is no stall.
- Stall, S1 held: S1 re-reads the file and re-bypasses every cycle, so writes landing during the stall are picked up.
- Stall, S2 held: S2 holds captured operands unchanged. Physical registers are single-assignment while live, so there is no re-bypass.
- Flush: at the next edge S1 and S2 valids clear, and no issue is accepted that cycle (flush overrides load). Data registers are not cleared.
- Reset (reset == 0 at posedge):
  - All valids clear, and S1 addresses clear to 0.
  - out_valid_o = 0, rd_addr_o = 0, out_operand_o and out_payload_o = 0.
  - issue_ready_o = 1 on the first cycle after reset.
  - Reset mid-stall discards both packets.
- Boundary: the same address on several read slots resolves independently and identically. Multiple write ports hitting one address resolve by highest port index. Simultaneous flush and out_ready_i: flush wins, and the packet is dropped.

Decomposition:
- Shared package: SRAM_DEPTH/SRAM_INDEX/SRAM_WIDTH defaults, LANES, WR_PORTS, slot-index helper constants (2l+k mapping).
- One natural sub-module: prf_bypass_mux. One instance per read slot, taking addr, rd_data and the WR_PORTS write bus, returning the resolved operand with the highest-port priority. The parent instantiates 12 of them.

Test Plan:
- Reset:
  - Stimulus: reset = 0 for 2 cycles, then reset = 1.
  - Required: out_valid_o = 0, rd_addr_o = 0, issue_ready_o = 1.
- Straight read:
  - Stimulus: preload reg 7 = 0xDEADBEEF; issue lane 0 src0 = 7.
  - Required: next cycle out_valid_o[0] = 1 and operand slot 0 = 0xDEADBEEF.
- Bypass priority:
  - Stimulus: S1 slot 3 addr = 9; same cycle wr_we_i[1] = 1 with (9, 0x11) and wr_we_i[4] = 1 with (9, 0x44).
  - Required: captured operand = 0x00000044.
- Stall:
  - Stimulus: out_ready_i = 0 with S1 and S2 full; write reg 5 = 0xABCD while S1 holds src = 5; release stall.
  - Required: issue_ready_o = 0 throughout the stall; S2 output unchanged; the S1 packet later emerges with 0xABCD.
- Flush:
  - Stimulus: flush_i = 1 together with issue_valid_i = 6'h3F and out_ready_i = 1.
  - Required: next cycle out_valid_o = 0, and nothing from that issue ever appears.
- Back-to-back throughput:
  - Stimulus: 8 consecutive all-lane issues with out_ready_i = 1.
  - Required: 8 consecutive output cycles, each packet in order with correct payloads.

Source files
------------

// File: rtl/prf_read_stage_pkg.sv
// Shared sizing, types and slot-mapping helpers for the register-read stage and its bypass muxes.
package prf_read_stage_pkg;

  localparam int unsigned SRAM_DEPTH    = 32;
  localparam int unsigned SRAM_INDEX    = 5;
  localparam int unsigned SRAM_WIDTH    = 32;
  localparam int unsigned LANES         = 6;
  localparam int unsigned WR_PORTS      = 6;
  localparam int unsigned PAYLOAD_WIDTH = 16;
  localparam int unsigned SLOTS         = 2 * LANES;

  typedef logic [SRAM_INDEX-1:0]    addr_t;
  typedef logic [SRAM_WIDTH-1:0]    data_t;
  typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

  // Operand k of lane l lives in read slot 2l+k.
  function automatic int unsigned slot_of(int unsigned lane, int unsigned k);
    return 2 * lane + k;
  endfunction

  function automatic int unsigned lane_of(int unsigned slot);
    return slot / 2;
  endfunction

endpackage

// File: rtl/prf_read_stage_if.sv
// Issue, register-file and output bundle of the register-read stage; slave is the stage side.
interface prf_read_stage_if;
  import prf_read_stage_pkg::*;

  logic                             flush_i;
  logic [LANES-1:0]                 issue_valid_i;
  logic                             issue_ready_o;
  logic [SLOTS*SRAM_INDEX-1:0]      src_addr_i;
  logic [LANES*PAYLOAD_WIDTH-1:0]   payload_i;
  logic [SLOTS*SRAM_INDEX-1:0]      rd_addr_o;
  logic [SLOTS*SRAM_WIDTH-1:0]      rd_data_i;
  logic [WR_PORTS-1:0]              wr_we_i;
  logic [WR_PORTS*SRAM_INDEX-1:0]   wr_addr_i;
  logic [WR_PORTS*SRAM_WIDTH-1:0]   wr_data_i;
  logic [LANES-1:0]                 out_valid_o;
  logic                             out_ready_i;
  logic [SLOTS*SRAM_WIDTH-1:0]      out_operand_o;
  logic [LANES*PAYLOAD_WIDTH-1:0]   out_payload_o;

  modport master (
    output flush_i, issue_valid_i, src_addr_i, payload_i, rd_data_i,
           wr_we_i, wr_addr_i, wr_data_i, out_ready_i,
    input  issue_ready_o, rd_addr_o, out_valid_o, out_operand_o, out_payload_o
  );

  modport slave (
    input  flush_i, issue_valid_i, src_addr_i, payload_i, rd_data_i,
           wr_we_i, wr_addr_i, wr_data_i, out_ready_i,
    output issue_ready_o, rd_addr_o, out_valid_o, out_operand_o, out_payload_o
  );

endinterface

// File: rtl/prf_bypass_mux.sv
// One read slot's writeback bypass: the highest-numbered write port hitting the address wins,
// otherwise the file's read data passes through.
module prf_bypass_mux
  import prf_read_stage_pkg::*;
#(
  parameter int unsigned NumPorts = WR_PORTS
) (
  input  addr_t                          addr_i,
  input  data_t                          rd_data_i,
  input  logic [NumPorts-1:0]            wr_we_i,
  input  logic [NumPorts*SRAM_INDEX-1:0] wr_addr_i,
  input  logic [NumPorts*SRAM_WIDTH-1:0] wr_data_i,
  output data_t                          operand_o
);

  // Priority chain: later ports override earlier ones, matching the file's last-write-wins.
  data_t chain [NumPorts+1];

  assign chain[0] = rd_data_i;

  for (genvar w = 0; w < NumPorts; w++) begin : g_port
    logic hit;
    assign hit = wr_we_i[w] && (wr_addr_i[w*SRAM_INDEX +: SRAM_INDEX] == addr_i);
    assign chain[w+1] = hit ? wr_data_i[w*SRAM_WIDTH +: SRAM_WIDTH] : chain[w];
  end

  assign operand_o = chain[NumPorts];

endmodule

// File: rtl/prf_read_stage.sv
// Register-read stage: S1 drives the file read addresses, S2 holds bypass-resolved operands
// behind a valid/ready handshake with flush.
module prf_read_stage
  import prf_read_stage_pkg::*;
(
  input logic             clk,
  input logic             reset,
  prf_read_stage_if.slave bus
);

  logic     [LANES-1:0] s1_valid_q, s1_valid_d;
  addr_t    [SLOTS-1:0] s1_addr_q, s1_addr_d;
  payload_t [LANES-1:0] s1_payload_q, s1_payload_d;

  logic     [LANES-1:0] s2_valid_q, s2_valid_d;
  data_t    [SLOTS-1:0] s2_operand_q, s2_operand_d;
  payload_t [LANES-1:0] s2_payload_q, s2_payload_d;

  data_t    [SLOTS-1:0] resolved;

  logic s1_occ, s2_occ, s1_adv, s2_adv, s1_load;

  assign s2_occ  = |s2_valid_q;
  assign s1_occ  = |s1_valid_q;
  assign s2_adv  = ~s2_occ | bus.out_ready_i;
  assign s1_adv  = ~s1_occ | s2_adv;
  assign s1_load = s1_adv & ~bus.flush_i & (|bus.issue_valid_i);

  // S1 re-resolves every cycle, so writes landing while S1 is held are picked up.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar k = 0; k < 2; k++) begin : g_src
      localparam int unsigned Slot = slot_of(l, k);

      prf_bypass_mux #(
        .NumPorts (WR_PORTS)
      ) u_bypass (
        .addr_i    (s1_addr_q[Slot]),
        .rd_data_i (bus.rd_data_i[Slot*SRAM_WIDTH +: SRAM_WIDTH]),
        .wr_we_i   (bus.wr_we_i),
        .wr_addr_i (bus.wr_addr_i),
        .wr_data_i (bus.wr_data_i),
        .operand_o (resolved[Slot])
      );

      assign s2_operand_d[Slot] = (s2_adv && s1_valid_q[l]) ? resolved[Slot]
                                                             : s2_operand_q[Slot];
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_addr_d    = s1_addr_q;
    s1_payload_d = s1_payload_q;
    if (s1_load) begin
      s1_valid_d   = bus.issue_valid_i;
      s1_addr_d    = bus.src_addr_i;
      s1_payload_d = bus.payload_i;
    end else if (s1_adv || bus.flush_i) begin
      s1_valid_d = '0;
    end

    s2_valid_d   = s2_valid_q;
    s2_payload_d = s2_payload_q;
    if (bus.flush_i) begin
      s2_valid_d = '0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv) begin
      s2_payload_d = s1_payload_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q   <= '0;
      s1_addr_q    <= '0;
      s1_payload_q <= '0;
      s2_valid_q   <= '0;
      s2_operand_q <= '0;
      s2_payload_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_payload_q <= s1_payload_d;
      s2_valid_q   <= s2_valid_d;
      s2_operand_q <= s2_operand_d;
      s2_payload_q <= s2_payload_d;
    end
  end

  assign bus.issue_ready_o = s1_adv;
  assign bus.rd_addr_o     = s1_addr_q;
  assign bus.out_valid_o   = s2_valid_q;
  assign bus.out_operand_o = s2_operand_q;
  assign bus.out_payload_o = s2_payload_q;

endmodule

// File: tb/tb_prf_read_stage.sv
// Bench for prf_read_stage: a behavioural register file feeds the stage; directed scenarios
// plus a randomized run against a two-entry pipeline model.
module tb_prf_read_stage;
  import prf_read_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prf_read_stage_if bus ();

  prf_read_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_t mem [SRAM_DEPTH];

  function automatic data_t init_val(addr_t a);
    return 32'hC0DE_0000 + {27'd0, a} * 32'h0001_0101;
  endfunction

  // Register file: writes land at the edge, later ports win.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < SRAM_DEPTH; i++)
        mem[i[SRAM_INDEX-1:0]] <= init_val(i[SRAM_INDEX-1:0]);
    end else begin
      for (int unsigned w = 0; w < WR_PORTS; w++)
        if (bus.wr_we_i[w +: 1] == 1'b1)
          mem[bus.wr_addr_i[w*SRAM_INDEX +: SRAM_INDEX]] <= bus.wr_data_i[w*SRAM_WIDTH +: SRAM_WIDTH];
    end
  end

  always_comb begin
    bus.rd_data_i = '0;
    for (int unsigned s = 0; s < SLOTS; s++)
      bus.rd_data_i[s*SRAM_WIDTH +: SRAM_WIDTH] = mem[bus.rd_addr_o[s*SRAM_INDEX +: SRAM_INDEX]];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.flush_i       = 1'b0;
    bus.issue_valid_i = '0;
    bus.src_addr_i    = '0;
    bus.payload_i     = '0;
    bus.wr_we_i       = '0;
    bus.wr_addr_i     = '0;
    bus.wr_data_i     = '0;
    bus.out_ready_i   = 1'b1;
  endtask

  task automatic set_src(int unsigned slot, addr_t a);
    bus.src_addr_i[slot*SRAM_INDEX +: SRAM_INDEX] = a;
  endtask

  task automatic set_wr(int unsigned port, addr_t a, data_t d);
    bus.wr_we_i[port +: 1] = 1'b1;
    bus.wr_addr_i[port*SRAM_INDEX +: SRAM_INDEX] = a;
    bus.wr_data_i[port*SRAM_WIDTH +: SRAM_WIDTH] = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_init = 1'b1;
    drive_idle();
    bus.issue_valid_i = 6'h3F;
    bus.src_addr_i = {$urandom, $urandom};
    bus.out_ready_i = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h00) begin n_fail++;
      $display("FAIL reset_valid got=%h exp=00", bus.out_valid_o); end
    n_cmp++; if (bus.rd_addr_o !== '0) begin n_fail++;
      $display("FAIL reset_rd_addr got=%h exp=0", bus.rd_addr_o); end
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready got=%b exp=1", bus.issue_ready_o); end
    n_cmp++; if (bus.out_operand_o !== '0 || bus.out_payload_o !== '0) begin n_fail++;
      $display("FAIL reset_data got=%h/%h exp=0", bus.out_operand_o, bus.out_payload_o); end
    reset = 1'b1;
    mem_init = 1'b0;
    drive_idle();
    tick();
    n_cmp++; if (bus.issue_ready_o !== 1'b1 || bus.out_valid_o !== 6'h00) begin n_fail++;
      $display("FAIL post_reset got ready=%b valid=%h exp ready=1 valid=00",
               bus.issue_ready_o, bus.out_valid_o); end
  endtask

  task automatic test_straight_read();
    drive_idle();
    set_wr(0, 5'd7, 32'hDEADBEEF);
    tick();
    drive_idle();
    bus.issue_valid_i = 6'h01;
    set_src(0, 5'd7);
    bus.payload_i[15:0] = 16'h1234;
    #1;
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL straight_ready got=%b exp=1", bus.issue_ready_o); end
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h00 || bus.rd_addr_o[4:0] !== 5'd7) begin n_fail++;
      $display("FAIL straight_s1 got valid=%h addr=%0d exp valid=00 addr=7",
               bus.out_valid_o, bus.rd_addr_o[4:0]); end
    drive_idle();
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h01 || bus.out_operand_o[31:0] !== 32'hDEADBEEF
                 || bus.out_payload_o[15:0] !== 16'h1234) begin n_fail++;
      $display("FAIL straight_out got valid=%h op=%h pl=%h exp 01/deadbeef/1234",
               bus.out_valid_o, bus.out_operand_o[31:0], bus.out_payload_o[15:0]); end
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h00) begin n_fail++;
      $display("FAIL straight_drain got=%h exp=00", bus.out_valid_o); end
  endtask

  task automatic test_bypass_priority();
    drive_idle();
    bus.issue_valid_i = 6'h03;
    set_src(0, 5'd1);
    set_src(1, 5'd2);
    set_src(2, 5'd9);
    set_src(3, 5'd9);
    tick();
    drive_idle();
    set_wr(1, 5'd9, 32'h11);
    set_wr(4, 5'd9, 32'h44);
    set_wr(5, 5'd10, 32'h55);
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h03) begin n_fail++;
      $display("FAIL bypass_valid got=%h exp=03", bus.out_valid_o); end
    n_cmp++; if (bus.out_operand_o[3*32 +: 32] !== 32'h44) begin n_fail++;
      $display("FAIL bypass_slot3 got=%h exp=00000044", bus.out_operand_o[3*32 +: 32]); end
    n_cmp++; if (bus.out_operand_o[2*32 +: 32] !== 32'h44) begin n_fail++;
      $display("FAIL bypass_slot2 got=%h exp=00000044", bus.out_operand_o[2*32 +: 32]); end
    n_cmp++; if (bus.out_operand_o[31:0] !== init_val(5'd1)) begin n_fail++;
      $display("FAIL bypass_nohit got=%h exp=%h", bus.out_operand_o[31:0], init_val(5'd1)); end
    drive_idle();
    tick();
  endtask

  task automatic test_stall();
    drive_idle();
    bus.out_ready_i = 1'b0;
    bus.issue_valid_i = 6'h01;
    set_src(0, 5'd3);
    bus.payload_i[15:0] = 16'hAAAA;
    tick();
    set_src(0, 5'd5);
    bus.payload_i[15:0] = 16'hBBBB;
    #1;
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL stall_fill_ready got=%b exp=1", bus.issue_ready_o); end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive_idle();
      bus.out_ready_i = 1'b0;
      if (c == 0) set_wr(0, 5'd5, 32'hABCD);
      #1;
      n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_fail++;
        $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, bus.issue_ready_o); end
      tick();
      n_cmp++; if (bus.out_valid_o !== 6'h01 || bus.out_operand_o[31:0] !== init_val(5'd3)
                   || bus.out_payload_o[15:0] !== 16'hAAAA) begin n_fail++;
        $display("FAIL stall_hold cyc=%0d got %h/%h/%h exp 01/%h/aaaa", c, bus.out_valid_o,
                 bus.out_operand_o[31:0], bus.out_payload_o[15:0], init_val(5'd3)); end
    end
    drive_idle();
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h01 || bus.out_operand_o[31:0] !== 32'hABCD
                 || bus.out_payload_o[15:0] !== 16'hBBBB) begin n_fail++;
      $display("FAIL stall_release got %h/%h/%h exp 01/0000abcd/bbbb", bus.out_valid_o,
               bus.out_operand_o[31:0], bus.out_payload_o[15:0]); end
    tick();
    // Reset while both registers are full and stalled discards both packets.
    bus.out_ready_i = 1'b0;
    bus.issue_valid_i = 6'h3F;
    tick();
    tick();
    reset = 1'b0;
    drive_idle();
    bus.out_ready_i = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h00 || bus.issue_ready_o !== 1'b1) begin n_fail++;
      $display("FAIL reset_mid_stall got valid=%h ready=%b exp 00/1",
               bus.out_valid_o, bus.issue_ready_o); end
    drive_idle();
  endtask

  task automatic test_flush();
    drive_idle();
    bus.issue_valid_i = 6'h3F;
    bus.payload_i = {6{16'h1111}};
    tick();
    bus.payload_i = {6{16'h2222}};
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h3F) begin n_fail++;
      $display("FAIL flush_prefill got=%h exp=3f", bus.out_valid_o); end
    bus.flush_i = 1'b1;
    bus.payload_i = {6{16'hF1F1}};
    tick();
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (bus.out_valid_o !== 6'h00) begin n_fail++;
        $display("FAIL flush_drop cyc=%0d got=%h exp=00", c, bus.out_valid_o); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [SLOTS*SRAM_INDEX-1:0]    srcs [8];
    logic [LANES*PAYLOAD_WIDTH-1:0] pls [8];
    for (int i = 0; i < 8; i++) begin
      srcs[i] = {$urandom, $urandom};
      pls[i]  = {$urandom, $urandom, $urandom};
    end
    for (int i = 0; i <= 8; i++) begin
      drive_idle();
      if (i < 8) begin
        bus.issue_valid_i = 6'h3F;
        bus.src_addr_i = srcs[i];
        bus.payload_i = pls[i];
      end
      #1;
      n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_fail++;
        $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.issue_ready_o); end
      tick();
      if (i >= 1) begin
        n_cmp++; if (bus.out_valid_o !== 6'h3F || bus.out_payload_o !== pls[i-1]) begin
          n_fail++;
          $display("FAIL b2b_pkt i=%0d got %h/%h exp 3f/%h", i-1, bus.out_valid_o,
                   bus.out_payload_o, pls[i-1]); end
        for (int s = 0; s < SLOTS; s++) begin
          n_cmp++;
          if (bus.out_operand_o[s*32 +: 32] !== mem[srcs[i-1][s*SRAM_INDEX +: SRAM_INDEX]]) begin
            n_fail++;
            $display("FAIL b2b_op pkt=%0d slot=%0d got=%h exp=%h", i-1, s,
                     bus.out_operand_o[s*32 +: 32], mem[srcs[i-1][s*SRAM_INDEX +: SRAM_INDEX]]);
          end
        end
      end
    end
    tick();
    n_cmp++; if (bus.out_valid_o !== 6'h00) begin n_fail++;
      $display("FAIL b2b_drain got=%h exp=00", bus.out_valid_o); end
  endtask

  // Two-entry pipeline model: operands are the register contents just after the edge on which
  // the packet leaves S1 (same-edge writes are therefore seen).
  task automatic test_random();
    logic [LANES-1:0]               m1_v, m2_v, cap_v;
    logic [SLOTS*SRAM_INDEX-1:0]    m1_a, cap_a;
    logic [LANES*PAYLOAD_WIDTH-1:0] m1_p, m2_p;
    logic [SLOTS*SRAM_WIDTH-1:0]    m2_op;
    logic adv1, adv2, cap;
    reset = 1'b0;
    drive_idle();
    tick();
    reset = 1'b1;
    m1_v = '0; m2_v = '0; m1_a = '0; m1_p = '0; m2_p = '0; m2_op = '0;
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      bus.issue_valid_i = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
      bus.src_addr_i    = {$urandom, $urandom};
      bus.payload_i     = {$urandom, $urandom, $urandom};
      bus.out_ready_i   = ($urandom_range(0, 2) != 0);
      bus.flush_i       = ($urandom_range(0, 19) == 0);
      bus.wr_we_i       = 6'($urandom & $urandom);
      bus.wr_addr_i     = 30'($urandom);
      bus.wr_data_i     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
      adv2 = (m2_v == '0) || bus.out_ready_i;
      adv1 = (m1_v == '0) || adv2;
      n_cmp++; if (bus.issue_ready_o !== adv1) begin n_fail++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, bus.issue_ready_o, adv1); end
      cap = adv2;
      cap_v = m1_v;
      cap_a = m1_a;
      if (adv2) begin
        m2_v = m1_v;
        m2_p = m1_p;
      end
      if (adv1) begin
        if (!bus.flush_i && bus.issue_valid_i != '0) begin
          m1_v = bus.issue_valid_i;
          m1_a = bus.src_addr_i;
          m1_p = bus.payload_i;
        end else begin
          m1_v = '0;
        end
      end
      if (bus.flush_i) begin
        m1_v = '0;
        m2_v = '0;
      end
      tick();
      if (cap)
        for (int unsigned s = 0; s < SLOTS; s++)
          if (cap_v[lane_of(s) +: 1] == 1'b1)
            m2_op[s*SRAM_WIDTH +: SRAM_WIDTH] = mem[cap_a[s*SRAM_INDEX +: SRAM_INDEX]];
      n_cmp++; if (bus.out_valid_o !== m2_v) begin n_fail++;
        $display("FAIL rnd_valid cyc=%0d got=%h exp=%h", c, bus.out_valid_o, m2_v); end
      n_cmp++; if (bus.rd_addr_o !== m1_a) begin n_fail++;
        $display("FAIL rnd_rd_addr cyc=%0d got=%h exp=%h", c, bus.rd_addr_o, m1_a); end
      for (int unsigned l = 0; l < LANES; l++) begin
        if (m2_v[l +: 1] == 1'b1) begin
          n_cmp++;
          if (bus.out_payload_o[l*16 +: 16] !== m2_p[l*16 +: 16]
              || bus.out_operand_o[l*64 +: 64] !== m2_op[l*64 +: 64]) begin
            n_fail++;
            $display("FAIL rnd_lane cyc=%0d lane=%0d got %h/%h exp %h/%h", c, l,
                     bus.out_payload_o[l*16 +: 16], bus.out_operand_o[l*64 +: 64],
                     m2_p[l*16 +: 16], m2_op[l*64 +: 64]);
          end
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b0;
    mem_init = 1'b1;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_straight_read();
    test_bypass_priority();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
